// File: rtl/jp_pkg.sv
// Shared definitions for the joypad responder: FSM states, button bit positions
// and frame constants.
package jp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      EMPTY
   } jp_state_e;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   localparam int unsigned BITS_PER_FRAME = 8;
   localparam logic        SHIFT_FILL     = 1'b1;

endpackage

// File: rtl/jp_sync.sv
// Multi-flop synchronizer for one asynchronous input with a configurable
// depth and reset value.
module jp_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/jp_responder.sv
// Joypad responder: latches buttons on the connector latch and shifts them out
// on the connector clock. Optional A/B turbo is enabled by defining JP_TURBO_EN.
module jp_responder
   import jp_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TURBO_DIV   = 4
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] buttons_in,
   input  logic       jp_latch_in,
   input  logic       jp_clk_in,
   output logic       jp_data_out,
   output logic       frame_out,
   output logic [3:0] bit_cnt_out
);

   logic                      latch_s, clk_s;
   logic                      latch_prev_q, clk_prev_q;
   logic                      latch_fall, clk_rise;
   jp_state_e                 state_q, state_d;
   logic [BITS_PER_FRAME-1:0] shift_q, shift_d, load_val;
   logic [3:0]                cnt_q, cnt_d;
   logic                      data_q, data_d;
   logic                      frame_q, frame_d;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("jp_responder: SYNC_STAGES must be in 2..4");
   end
   if (TURBO_DIV < 1 || TURBO_DIV > 15) begin : g_bad_turbo
      $error("jp_responder: TURBO_DIV must be in 1..15");
   end

   jp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_latch (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .d_i   (jp_latch_in),
      .q_o   (latch_s)
   );

   jp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .d_i   (jp_clk_in),
      .q_o   (clk_s)
   );

   assign latch_fall = latch_prev_q & ~latch_s;
   assign clk_rise   = clk_s & ~clk_prev_q;

`ifdef JP_TURBO_EN
   logic [3:0] turbo_cnt_q, turbo_cnt_d;
   logic       turbo_phase_q, turbo_phase_d;

   always_comb begin
      turbo_cnt_d   = turbo_cnt_q;
      turbo_phase_d = turbo_phase_q;
      if (latch_fall) begin
         if (turbo_cnt_q == 4'(TURBO_DIV - 1)) begin
            turbo_cnt_d   = '0;
            turbo_phase_d = ~turbo_phase_q;
         end else begin
            turbo_cnt_d = turbo_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         turbo_cnt_q   <= '0;
         turbo_phase_q <= 1'b0;
      end else begin
         turbo_cnt_q   <= turbo_cnt_d;
         turbo_phase_q <= turbo_phase_d;
      end
   end

   always_comb begin
      load_val        = buttons_in;
      load_val[BTN_A] = buttons_in[BTN_A] & turbo_phase_q;
      load_val[BTN_B] = buttons_in[BTN_B] & turbo_phase_q;
   end
`else
   assign load_val = buttons_in;
`endif

   // Latch level outranks everything, so a clock edge seen together with it never shifts.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      frame_d = 1'b0;
      if (latch_s) begin
         state_d = LOAD;
         shift_d = load_val;
      end else if (latch_fall) begin
         state_d = SHIFT;
         cnt_d   = '0;
         frame_d = 1'b1;
      end else begin
         case (state_q)
            SHIFT: begin
               if (clk_rise) begin
                  shift_d = {SHIFT_FILL, shift_q[BITS_PER_FRAME-1:1]};
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'(BITS_PER_FRAME - 1)) begin
                     state_d = EMPTY;
                  end
               end
            end
            LOAD:    state_d = IDLE;
            default: ;
         endcase
      end
      data_d = (state_q == EMPTY) ? 1'b0 : ~shift_q[0];
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         latch_prev_q <= 1'b0;
         clk_prev_q   <= 1'b1;
         state_q      <= IDLE;
         shift_q      <= '0;
         cnt_q        <= '0;
         data_q       <= 1'b1;
         frame_q      <= 1'b0;
      end else begin
         latch_prev_q <= latch_s;
         clk_prev_q   <= clk_s;
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         frame_q      <= frame_d;
      end
   end

   assign jp_data_out = data_q;
   assign frame_out   = frame_q;
   assign bit_cnt_out = cnt_q;

endmodule

// File: tb/tb_jp_responder.sv
// Self-checking bench for jp_responder: two instances (SYNC_STAGES 2 and 3)
// share one set of pins; table-driven frames plus corner-case sequences.
module tb_jp_responder;

   localparam int unsigned TB_TURBO_DIV = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] buttons;
   logic       jp_latch;
   logic       jp_clk;
   logic       data2, frame2, data3, frame3;
   logic [3:0] cnt2, cnt3;

   int unsigned pass_cnt = 0;
   int unsigned tot_cnt  = 0;
   int          fc2 = 0;
   int          fc3 = 0;
   int          tb_frames = 0;
   int unsigned t_cnt = 0;
   logic        t_phase = 1'b0;
   logic        sb_q[$];

   always #5 clk = ~clk;

   jp_responder #(.SYNC_STAGES(2), .TURBO_DIV(TB_TURBO_DIV)) dut2 (
      .clk_in      (clk),
      .rst_in      (rst),
      .buttons_in  (buttons),
      .jp_latch_in (jp_latch),
      .jp_clk_in   (jp_clk),
      .jp_data_out (data2),
      .frame_out   (frame2),
      .bit_cnt_out (cnt2)
   );

   jp_responder #(.SYNC_STAGES(3), .TURBO_DIV(TB_TURBO_DIV)) dut3 (
      .clk_in      (clk),
      .rst_in      (rst),
      .buttons_in  (buttons),
      .jp_latch_in (jp_latch),
      .jp_clk_in   (jp_clk),
      .jp_data_out (data3),
      .frame_out   (frame3),
      .bit_cnt_out (cnt3)
   );

   always_ff @(posedge clk) begin
      if (frame2) fc2 <= fc2 + 1;
      if (frame3) fc3 <= fc3 + 1;
   end

   typedef struct packed {
      logic [7:0] btn;
      logic [7:0] ser;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string nm, input int act, input int exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_word(input logic [7:0] ser);
      logic [7:0] r;
      r = ser;
`ifdef JP_TURBO_EN
      if (!t_phase) r[1:0] = 2'b11;
`endif
      return r;
   endfunction

   task automatic latch_hi();
      jp_latch = 1'b1;
      tick(8);
   endtask

   task automatic latch_lo();
      jp_latch = 1'b0;
      tick(8);
      tb_frames++;
      if (t_cnt == TB_TURBO_DIV - 1) begin
         t_cnt   = 0;
         t_phase = ~t_phase;
      end else begin
         t_cnt++;
      end
   endtask

   task automatic load_frame(input logic [7:0] b);
      buttons = b;
      latch_hi();
      latch_lo();
   endtask

   task automatic pulse();
      jp_clk = 1'b0;
      tick(8);
      jp_clk = 1'b1;
      tick(8);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      rst     = 1'b0;
      t_cnt   = 0;
      t_phase = 1'b0;
      tick(2);
   endtask

   initial begin
      logic [7:0] e;
      logic       exp_bit;

      vecs[0] = '{btn: 8'h05, ser: 8'hFA};
      vecs[1] = '{btn: 8'hFF, ser: 8'h00};
      vecs[2] = '{btn: 8'h00, ser: 8'hFF};
      vecs[3] = '{btn: 8'hA5, ser: 8'h5A};
      vecs[4] = '{btn: 8'h3C, ser: 8'hC3};

      rst = 1'b1; buttons = 8'h00; jp_latch = 1'b0; jp_clk = 1'b1;
      tick(3);
      check("rst_data2", int'(data2), 1);
      check("rst_frame2", int'(frame2), 0);
      check("rst_cnt2", int'(cnt2), 0);
      check("rst_data3", int'(data3), 1);
      check("rst_cnt3", int'(cnt3), 0);
      rst = 1'b0;
      tick(3);
      check("idle_data2", int'(data2), 1);

      // Buttons are changed after the load to show the shift register ignores them.
      foreach (vecs[v]) begin
         e = exp_word(vecs[v].ser);
         buttons = vecs[v].btn;
         latch_hi();
         latch_lo();
         buttons = ~vecs[v].btn;
         for (int i = 0; i < 8; i++) sb_q.push_back(e[i]);
         sb_q.push_back(1'b0);
         for (int i = 0; i <= 8; i++) begin
            exp_bit = sb_q.pop_front();
            check($sformatf("v%0d_bit%0d_data2", v, i), int'(data2), int'(exp_bit));
            check($sformatf("v%0d_bit%0d_data3", v, i), int'(data3), int'(exp_bit));
            check($sformatf("v%0d_bit%0d_cnt2", v, i), int'(cnt2), i);
            if (i < 8) pulse();
         end
         check($sformatf("v%0d_frames2", v), fc2, tb_frames);
         check($sformatf("v%0d_frames3", v), fc3, tb_frames);
      end

      for (int i = 0; i < 4; i++) begin
         pulse();
         check("empty_data2", int'(data2), 0);
         check("empty_cnt2", int'(cnt2), 8);
         check("empty_data3", int'(data3), 0);
         check("empty_cnt3", int'(cnt3), 8);
      end

      e = exp_word(8'hFE);
      load_frame(8'h01);
      pulse();
      pulse();
      check("pre_coll_data2", int'(data2), 1);
      check("pre_coll_cnt2", int'(cnt2), 2);
      jp_clk = 1'b0;
      tick(8);
      jp_latch = 1'b1;
      jp_clk   = 1'b1;
      tick(8);
      check("coll_cnt2", int'(cnt2), 2);
      check("coll_cnt3", int'(cnt3), 2);
      check("coll_data2", int'(data2), int'(e[0]));
      latch_lo();
      check("post_coll_data2", int'(data2), int'(e[0]));
      check("post_coll_cnt2", int'(cnt2), 0);
      pulse();
      check("post_coll_shift_data2", int'(data2), int'(e[1]));
      check("post_coll_shift_cnt2", int'(cnt2), 1);

      load_frame(8'hFF);
      repeat (3) pulse();
      check("pre_rst_data2", int'(data2), 0);
      check("pre_rst_cnt2", int'(cnt2), 3);
      rst = 1'b1;
      #1;
      check("async_rst_data2", int'(data2), 1);
      check("async_rst_cnt2", int'(cnt2), 0);
      check("async_rst_data3", int'(data3), 1);
      check("async_rst_cnt3", int'(cnt3), 0);
      tick(2);
      rst     = 1'b0;
      t_cnt   = 0;
      t_phase = 1'b0;
      tick(2);
      for (int i = 0; i < 3; i++) begin
         pulse();
         check("after_rst_data2", int'(data2), 1);
         check("after_rst_cnt2", int'(cnt2), 0);
         check("after_rst_data3", int'(data3), 1);
      end
      e = exp_word(8'h00);
      load_frame(8'hFF);
      check("relatch_data2", int'(data2), int'(e[0]));

      load_frame(8'h04);
      pulse();
      check("lat_pre_data2", int'(data2), 1);
      check("lat_pre_data3", int'(data3), 1);
      jp_clk = 1'b0;
      tick(8);
      jp_clk = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         check($sformatf("lat_s2_k%0d", k), int'(data2), (k >= 4) ? 0 : 1);
         check($sformatf("lat_s3_k%0d", k), int'(data3), (k >= 5) ? 0 : 1);
      end

`ifdef JP_TURBO_EN
      do_reset();
      load_frame(8'h01);
      check("turbo_f1", int'(data2), 1);
      load_frame(8'h01);
      check("turbo_f2", int'(data2), 1);
      load_frame(8'h01);
      check("turbo_f3", int'(data2), 0);
      load_frame(8'h01);
      check("turbo_f4", int'(data2), 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/jp_responder.md
JP_RESPONDER -- requirements
Module: jp_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on jp_latch_in and jp_clk_in, legal range 2..4.
REQ-002 SHALL have parameter TURBO_DIV, default 4: latch-fall count between turbo phase toggles, legal range 1..15 (used only when JP_TURBO_EN is defined).
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port buttons_in, input, 8 bits: active-high pressed; bit order 0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-006 SHALL have port jp_latch_in, input, 1 bit: asynchronous connector latch; high = parallel load.
REQ-007 SHALL have port jp_clk_in, input, 1 bit: asynchronous connector clock; idles high; shifts on its rising edge.
REQ-008 SHALL have port jp_data_out, output, 1 bit: registered serial data, active-low (0 = pressed).
REQ-009 SHALL have port frame_out, output, 1 bit: one-cycle pulse on each synchronized latch falling edge.
REQ-010 SHALL have port bit_cnt_out, output, 4 bits: bits shifted since the last load, saturating at 8.

Function
REQ-011 SHALL pass jp_latch_in and jp_clk_in through SYNC_STAGES flops each, then through an edge-detect register.
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT and EMPTY.
REQ-013 SHALL enter LOAD from any state on a synchronized latch high and reload shift_reg from buttons_in every cycle while in LOAD.
REQ-014 SHALL ignore clock rising edges while latch is high.
REQ-015 SHALL, on a latch falling edge, go LOAD->SHIFT, clear bit_cnt and pulse frame_out.
REQ-016 SHALL, in SHIFT on each synchronized clock rising edge, shift shift_reg right, fill the MSB with 1 and increment bit_cnt.
REQ-017 SHALL go SHIFT->EMPTY when bit_cnt reaches 8, where jp_data_out is held 0 and further clock edges leave all state unchanged.
REQ-018 SHALL give latch priority when a latch rising edge and a clock rising edge are detected in the same cycle: enter LOAD and do not shift.
REQ-019 SHALL drive jp_data_out registered as ~shift_reg[0], updating exactly SYNC_STAGES+2 clk_in cycles after the pin transition it reflects.
REQ-020 SHALL keep shift_reg unchanged when buttons_in changes outside LOAD.

Reset
REQ-021 SHALL, while rst_in is high: state=IDLE, shift_reg=8'h00, bit_cnt=0, jp_data_out=1, frame_out=0, synchronizer flops=latch 0 / clk 1, turbo counter=0, turbo phase=0.
REQ-022 SHALL, on a reset mid-SHIFT, abandon the partial frame; no output SHALL change until the next latch high.

Configuration
REQ-023 SHALL, with JP_TURBO_EN defined, apply turbo to A and B: loaded bits 0 and 1 = buttons_in bit AND turbo_phase.
REQ-024 SHALL, with JP_TURBO_EN defined, toggle turbo_phase every TURBO_DIV frame_out pulses via a 4-bit counter.
REQ-025 SHALL, without JP_TURBO_EN, load buttons_in unmodified and include no turbo counter or phase logic.

Structure
REQ-026 SHALL place in shared package jp_pkg: the FSM state enum, button bit-index constants, the BITS_PER_FRAME=8 constant and the shift fill value.
REQ-027 SHALL implement the synchronizer as sub-module jp_sync (parameterized depth and reset value) and instantiate it twice.

Verification
REQ-028 Buttons 8'b0000_0101, latch pulse, then 8 clock pulses -> jp_data_out sequence 0,1,0,1,1,1,1,1 (A, B, Select, Start, Up, Down, Left, Right).
REQ-029 After 8 shifts, 4 more clock pulses -> jp_data_out stays 0 and bit_cnt_out stays 8.
REQ-030 Latch rise and clock rise on the same clk_in edge -> no shift, state LOAD, and bit 0 presented after latch fall.
REQ-031 rst_in asserted after 3 shifts -> jp_data_out=1 and bit_cnt_out=0 immediately, unchanged until the next latch.
REQ-032 JP_TURBO_EN with TURBO_DIV=2 and A held -> A bit reads released, released, pressed, pressed across four consecutive frames.
REQ-033 Pin clock edge -> jp_data_out changes exactly SYNC_STAGES+2 cycles later, for both SYNC_STAGES=2 and SYNC_STAGES=3.
